// File: rtl/axi_lite_reg_slave_pkg.sv
// Shared types, response codes and address decode for the AXI4-lite register target.
package axi_lite_pkg;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // True when the byte address is word-aligned and selects an existing register.
    function automatic logic addr_ok(input logic [31:0] addr, input int num_regs);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < $unsigned(num_regs));
    endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-lite single-beat bus with master and slave views.
interface axi_lite_inf #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIAE = 32
);
    logic                 awvalid;
    logic                 awready;
    logic [ADDR_SIAE-1:0] awaddr;
    logic                 awid;
    logic                 awsize;
    logic                 wvalid;
    logic                 wready;
    logic [DATA_SIZE-1:0] wdata;
    logic                 wlast;
    logic                 bvalid;
    logic                 bready;
    logic                 bresp;
    logic                 bid;
    logic                 arvalid;
    logic                 arready;
    logic [ADDR_SIAE-1:0] araddr;
    logic                 arid;
    logic                 arsize;
    logic                 rvalid;
    logic                 rready;
    logic [DATA_SIZE-1:0] rdata;
    logic                 rlast;
    logic                 rid;
    logic                 rresp;

    modport master (
        output awvalid, awaddr, awid, awsize, wvalid, wdata, wlast, bready,
               arvalid, araddr, arid, arsize, rready,
        input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata,
               rlast, rid, rresp
    );

    modport slave (
        input  awvalid, awaddr, awid, awsize, wvalid, wdata, wlast, bready,
               arvalid, araddr, arid, arsize, rready,
        output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata,
               rlast, rid, rresp
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-lite register target: bank of NUM_REGS 32-bit registers, register 0 is a read-only ID.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int                   DATA_SIZE = 32,
    parameter int                   ADDR_SIAE = 32,
    parameter int                   NUM_REGS  = 8,
    parameter logic [DATA_SIZE-1:0] ID_VALUE  = 32'hA5A5_0001
) (
    input logic       clk,
    input logic       reset_n,
    axi_lite_inf.slave bus
);

    localparam int IDX_W = $clog2(NUM_REGS);

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [DATA_SIZE-1:0] regs [NUM_REGS];

    logic                 aw_got, w_got;
    logic [ADDR_SIAE-1:0] aw_addr_q;
    logic                 aw_id_q;
    logic [DATA_SIZE-1:0] w_data_q;
    logic                 bresp_q, bid_q;

    logic                 aw_hs, w_hs, commit, wr_good, wr_id;
    logic [ADDR_SIAE-1:0] wr_addr;
    logic [DATA_SIZE-1:0] wr_data;
    logic [IDX_W-1:0]     wr_idx;

    logic                 ar_hs;
    logic [IDX_W-1:0]     rd_idx;
    logic [DATA_SIZE-1:0] rdata_q;
    logic                 rresp_q, rid_q;

    // Size and last carry no information for single-beat full-word accesses.
    logic unused_inputs;
    assign unused_inputs = ^{bus.awsize, bus.wlast, bus.arsize};

    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    // Commit on the edge where the later of AW/W lands (or both together).
    assign commit  = (wr_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
    assign wr_addr = aw_got ? aw_addr_q : bus.awaddr;
    assign wr_id   = aw_got ? aw_id_q   : bus.awid;
    assign wr_data = w_got  ? w_data_q  : bus.wdata;
    assign wr_idx  = wr_addr[2 +: IDX_W];
    assign wr_good = addr_ok(wr_addr, NUM_REGS) && (wr_idx != '0);

    assign ar_hs   = bus.arvalid && bus.arready;
    assign rd_idx  = bus.araddr[2 +: IDX_W];

    assign bus.bresp = bresp_q;
    assign bus.bid   = bid_q;
    assign bus.rdata = rdata_q;
    assign bus.rresp = rresp_q;
    assign bus.rid   = rid_q;

    // Write FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wr_state <= W_IDLE;
        else          wr_state <= wr_next;
    end

    // Write FSM next state.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (commit)     wr_next = W_RESP;
            W_RESP:  if (bus.bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Write FSM outputs; readies are forced low while reset is held.
    always_comb begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                bus.awready = reset_n && !aw_got;
                bus.wready  = reset_n && !w_got;
            end
            W_RESP:  bus.bvalid = 1'b1;
            default: ;
        endcase
    end

    // Capture AW/W independently, latch the response at commit, clear on B handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            aw_id_q   <= 1'b0;
            w_data_q  <= '0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= 1'b0;
        end else if (wr_state == W_RESP) begin
            if (bus.bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end else begin
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_addr_q <= bus.awaddr;
                aw_id_q   <= bus.awid;
            end
            if (w_hs) begin
                w_got    <= 1'b1;
                w_data_q <= bus.wdata;
            end
            if (commit) begin
                bresp_q <= wr_good ? RESP_OKAY : RESP_ERR;
                bid_q   <= wr_id;
            end
        end
    end

    // Register bank; register 0 is never written, its reads return ID_VALUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && wr_good) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_state <= R_IDLE;
        else          rd_state <= rd_next;
    end

    // Read FSM next state.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs)      rd_next = R_DATA;
            R_DATA:  if (bus.rready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        case (rd_state)
            R_IDLE:  bus.arready = reset_n;
            R_DATA: begin
                bus.rvalid = 1'b1;
                bus.rlast  = 1'b1;
            end
            default: ;
        endcase
    end

    // Register read payload at AR handshake; a same-edge write is not yet visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rid_q   <= 1'b0;
        end else if (ar_hs) begin
            rid_q <= bus.arid;
            if (!addr_ok(bus.araddr, NUM_REGS)) begin
                rdata_q <= '0;
                rresp_q <= RESP_ERR;
            end else if (rd_idx == '0) begin
                rdata_q <= ID_VALUE;
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= regs[rd_idx];
                rresp_q <= RESP_OKAY;
            end
        end
    end

endmodule
